// File: rtl/result_formatter.sv
// Converts a signed decimal mantissa/exponent into normalised BCD digits,
// stripping trailing zeros into the exponent.
module result_formatter (
   input  logic        clock,
   input  logic        reset,
   input  logic        eval,
   input  logic        sign,
   input  logic [33:0] mant,
   input  logic [6:0]  exp,
   output logic        done,
   output logic        busy,
   output logic        signOut,
   output logic [43:0] digits,
   output logic [3:0]  numDigits,
   output logic [7:0]  expOut
);

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_TRIM, S_DONE} state_t;

   state_t      state_q, state_d;
   logic        eval_q;
   logic        armed_q;
   logic        sign_q, sign_d;
   logic [33:0] work_q, work_d;
   logic [7:0]  exp_q, exp_d;
   logic [43:0] buf_q, buf_d;
   logic [3:0]  idx_q, idx_d;
   logic [3:0]  nd_q, nd_d;
   logic        done_q, done_d;
   logic        sign_out_q, sign_out_d;
   logic [43:0] digits_q, digits_d;
   logic [3:0]  nd_out_q, nd_out_d;
   logic [7:0]  exp_out_q, exp_out_d;

   logic        start;
   logic [33:0] quot;
   logic [3:0]  rem;

   // armed_q blocks an eval held high across reset from counting as an edge
   assign start = eval & ~eval_q & armed_q;
   assign quot  = work_q / 34'd10;
   assign rem   = 4'(work_q % 34'd10);

   always_comb begin
      state_d    = state_q;
      sign_d     = sign_q;
      work_d     = work_q;
      exp_d      = exp_q;
      buf_d      = buf_q;
      idx_d      = idx_q;
      nd_d       = nd_q;
      done_d     = 1'b0;
      sign_out_d = sign_out_q;
      digits_d   = digits_q;
      nd_out_d   = nd_out_q;
      exp_out_d  = exp_out_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               // a zero mantissa always reports +0 * 10^0
               sign_d  = (mant != '0) ? sign : 1'b0;
               exp_d   = (mant != '0) ? {exp[6], exp} : '0;
               work_d  = mant;
               buf_d   = '0;
               idx_d   = '0;
               nd_d    = 4'd1;
               state_d = S_CONV;
            end
         end
         S_CONV: begin
            for (int unsigned i = 0; i < 11; i++) begin
               if (idx_q == 4'(i)) buf_d[4*i +: 4] = rem;
            end
            work_d = quot;
            idx_d  = idx_q + 4'd1;
            if (quot == '0) begin
               nd_d    = idx_q + 4'd1;
               state_d = S_TRIM;
            end
         end
         S_TRIM: begin
            if (buf_q[3:0] == 4'd0 && nd_q > 4'd1) begin
               buf_d = {4'd0, buf_q[43:4]};
               nd_d  = nd_q - 4'd1;
               exp_d = exp_q + 8'd1;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done_d     = 1'b1;
            sign_out_d = sign_q;
            digits_d   = buf_q;
            nd_out_d   = nd_q;
            exp_out_d  = exp_q;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         eval_q     <= 1'b0;
         armed_q    <= 1'b0;
         sign_q     <= 1'b0;
         work_q     <= '0;
         exp_q      <= '0;
         buf_q      <= '0;
         idx_q      <= '0;
         nd_q       <= 4'd1;
         done_q     <= 1'b0;
         sign_out_q <= 1'b0;
         digits_q   <= '0;
         nd_out_q   <= 4'd1;
         exp_out_q  <= '0;
      end else begin
         state_q    <= state_d;
         eval_q     <= eval;
         armed_q    <= armed_q | ~eval;
         sign_q     <= sign_d;
         work_q     <= work_d;
         exp_q      <= exp_d;
         buf_q      <= buf_d;
         idx_q      <= idx_d;
         nd_q       <= nd_d;
         done_q     <= done_d;
         sign_out_q <= sign_out_d;
         digits_q   <= digits_d;
         nd_out_q   <= nd_out_d;
         exp_out_q  <= exp_out_d;
      end
   end

   assign done      = done_q;
   assign busy      = (state_q != S_IDLE);
   assign signOut   = sign_out_q;
   assign digits    = digits_q;
   assign numDigits = nd_out_q;
   assign expOut    = exp_out_q;

endmodule
